// File: rtl/pc_ras_unit_pkg.sv
// Shared definitions for the program-counter unit and its return-address stack.
package pc_pkg;

    localparam int INSTR_BYTES = 4;

    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_BRANCH,
        SEL_JMP,
        SEL_CALL,
        SEL_RET
    } next_sel_t;

    // Width of a counter that must hold 0..depth inclusive.
    function automatic int ras_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pc_ras_unit_if.sv
// Fetch-control bundle between the pipeline control and the PC unit.
interface pc_ras_unit_if #(
    parameter int WIDTH     = 32,
    parameter int RAS_DEPTH = 4
);
    import pc_pkg::*;

    localparam int CW = ras_cnt_w(RAS_DEPTH);

    logic             stall;
    logic             zeroflag;
    logic             branchFlag;
    logic [WIDTH-1:0] branchOffset;
    logic             jmpFlag;
    logic [WIDTH-1:0] jmpAddress;
    logic             callFlag;
    logic             retFlag;
    logic [WIDTH-1:0] out;
    logic [CW-1:0]    rasCount;
    logic             rasOverflow;
    logic             rasUnderflow;

    modport master (
        output stall, zeroflag, branchFlag, branchOffset, jmpFlag, jmpAddress, callFlag, retFlag,
        input  out, rasCount, rasOverflow, rasUnderflow
    );

    modport slave (
        input  stall, zeroflag, branchFlag, branchOffset, jmpFlag, jmpAddress, callFlag, retFlag,
        output out, rasCount, rasOverflow, rasUnderflow
    );

endinterface

// File: rtl/pc_ras_unit_stack.sv
// Circular return-address stack: the oldest entry is silently overwritten when full,
// and the top entry is readable combinationally.
module pc_ras_stack
    import pc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic                        pop,
    input  logic [WIDTH-1:0]            push_data,
    output logic [WIDTH-1:0]            top,
    output logic [ras_cnt_w(DEPTH)-1:0] count,
    output logic                        overflow,
    output logic                        underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = ras_cnt_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    ptr_reg;
    logic [PW-1:0]    ptr_prev;
    logic [CW-1:0]    count_reg;
    logic             overflow_reg;
    logic             underflow_reg;
    logic             empty;
    logic             full;

    assign ptr_prev  = ptr_reg - PW'(1);
    assign empty     = (count_reg == '0);
    assign full      = (count_reg == CW'(DEPTH));
    assign top       = mem[ptr_prev];
    assign count     = count_reg;
    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;

    // Contents need no reset: count gates every read that matters.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_reg       <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            overflow_reg  <= push & full;
            underflow_reg <= pop & empty;
            if (push) begin
                ptr_reg <= ptr_reg + PW'(1);
                if (!full) begin
                    count_reg <= count_reg + CW'(1);
                end
            end else if (pop && !empty) begin
                ptr_reg   <= ptr_prev;
                count_reg <= count_reg - CW'(1);
            end
        end
    end

endmodule

// File: rtl/pc_ras_unit.sv
// Fetch-stage program counter with branch/jump/call/return select and an
// internal return-address stack.
module pc_ras_unit
    import pc_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int               RAS_DEPTH    = 4
) (
    input  logic         clk,
    input  logic         rst,
    pc_ras_unit_if.slave bus
);

    localparam int CW = ras_cnt_w(RAS_DEPTH);

    logic [WIDTH-1:0] pc_reg;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] seq;
    logic [WIDTH-1:0] branch_target;
    logic [WIDTH-1:0] ras_top;
    logic [CW-1:0]    ras_count;
    logic             ras_empty;
    logic             push;
    logic             pop;
    next_sel_t        sel;

    assign seq           = pc_reg + WIDTH'(INSTR_BYTES);
    assign branch_target = seq + (bus.branchOffset << 2);
    assign ras_empty     = (ras_count == '0);

    // A return outranks a call, so a simultaneous call never pushes.
    assign pop  = !bus.stall & bus.retFlag;
    assign push = !bus.stall & !bus.retFlag & bus.callFlag;

    always_comb begin
        sel = SEL_SEQ;
        if (bus.retFlag) begin
            sel = ras_empty ? SEL_SEQ : SEL_RET;
        end else if (bus.callFlag) begin
            sel = SEL_CALL;
        end else if (bus.jmpFlag) begin
            sel = SEL_JMP;
        end else if (bus.branchFlag && bus.zeroflag) begin
            sel = SEL_BRANCH;
        end
    end

    always_comb begin
        pc_next = seq;
        case (sel)
            SEL_RET:            pc_next = ras_top;
            SEL_CALL, SEL_JMP:  pc_next = bus.jmpAddress;
            SEL_BRANCH:         pc_next = branch_target;
            default:            pc_next = seq;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_reg <= RESET_VECTOR;
        end else if (!bus.stall) begin
            pc_reg <= pc_next;
        end
    end

    pc_ras_stack #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (seq),
        .top       (ras_top),
        .count     (ras_count),
        .overflow  (bus.rasOverflow),
        .underflow (bus.rasUnderflow)
    );

    assign bus.out      = pc_reg;
    assign bus.rasCount = ras_count;

endmodule

// File: tb/tb_pc_ras_unit.sv
// Directed bench for pc_ras_unit: sequential flow, branches, jumps, stalls,
// calls/returns with RAS overflow/underflow, and asynchronous reset.
module tb_pc_ras_unit;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   passes = 0;
    int   total  = 0;

    pc_ras_unit_if #(.WIDTH(32), .RAS_DEPTH(4)) bus ();

    pc_ras_unit #(
        .WIDTH        (32),
        .RESET_VECTOR (32'h0),
        .RAS_DEPTH    (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        $display("t=%0t %s observed=0x%0h expected=0x%0h", $time, tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.stall        = 1'b0;
        bus.zeroflag     = 1'b0;
        bus.branchFlag   = 1'b0;
        bus.branchOffset = '0;
        bus.jmpFlag      = 1'b0;
        bus.jmpAddress   = '0;
        bus.callFlag     = 1'b0;
        bus.retFlag      = 1'b0;
    endtask

    task automatic jump(input logic [31:0] addr);
        idle();
        bus.jmpFlag    = 1'b1;
        bus.jmpAddress = addr;
        step();
        idle();
    endtask

    task automatic call(input logic [31:0] addr);
        idle();
        bus.callFlag   = 1'b1;
        bus.jmpAddress = addr;
        step();
        idle();
    endtask

    initial begin
        idle();
        #50;
        chk("reset_out", bus.out, 32'h0);
        chk("reset_count", 32'(bus.rasCount), 32'd0);
        chk("reset_ovf", 32'(bus.rasOverflow), 32'd0);
        rst = 1'b1;
        #1;
        chk("release_out", bus.out, 32'h0);
        repeat (4) step();
        chk("seq_4_edges", bus.out, 32'h10);
        chk("seq_count", 32'(bus.rasCount), 32'd0);

        // Taken branch: 0x14 + (-3 << 2) = 0x08
        bus.branchFlag = 1'b1; bus.zeroflag = 1'b1; bus.branchOffset = -32'sd3;
        step();
        chk("branch_taken", bus.out, 32'h08);
        jump(32'h10);
        bus.branchFlag = 1'b1; bus.zeroflag = 1'b0; bus.branchOffset = -32'sd3;
        step();
        chk("branch_not_taken", bus.out, 32'h14);

        jump(32'h340C);
        chk("jmp", bus.out, 32'h340C);
        step();
        chk("jmp_seq", bus.out, 32'h3410);
        bus.stall = 1'b1; bus.jmpFlag = 1'b1; bus.jmpAddress = 32'h9000;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("stall_hold_%0d", i), bus.out, 32'h3410);
        end
        idle();
        step();
        chk("stall_release", bus.out, 32'h3414);

        jump(32'hFFFF_FFFC);
        step();
        chk("seq_wrap", bus.out, 32'h0);

        jump(32'h100);
        call(32'h2000);
        chk("call_out", bus.out, 32'h2000);
        chk("call_count", 32'(bus.rasCount), 32'd1);
        bus.retFlag = 1'b1;
        step();
        idle();
        chk("ret_out", bus.out, 32'h104);
        chk("ret_count", 32'(bus.rasCount), 32'd0);

        // Call+return on an empty RAS: return wins, underflows, nothing pushed
        bus.callFlag = 1'b1; bus.retFlag = 1'b1; bus.jmpAddress = 32'h3000;
        step();
        idle();
        chk("callret_empty_out", bus.out, 32'h108);
        chk("callret_empty_count", 32'(bus.rasCount), 32'd0);
        chk("callret_empty_udf", 32'(bus.rasUnderflow), 32'd1);
        call(32'h2000);
        bus.callFlag = 1'b1; bus.retFlag = 1'b1; bus.jmpAddress = 32'h3000;
        step();
        idle();
        chk("callret_full_out", bus.out, 32'h10C);
        chk("callret_full_count", 32'(bus.rasCount), 32'd0);

        jump(32'h100);
        call(32'h200);
        call(32'h300);
        call(32'h400);
        call(32'h500);
        chk("ovf_before", 32'(bus.rasOverflow), 32'd0);
        chk("count_4", 32'(bus.rasCount), 32'd4);
        call(32'h600);
        chk("ovf_pulse", 32'(bus.rasOverflow), 32'd1);
        chk("ovf_count", 32'(bus.rasCount), 32'd4);
        bus.retFlag = 1'b1;
        step();
        chk("ovf_clears", 32'(bus.rasOverflow), 32'd0);
        chk("ret1", bus.out, 32'h504);
        step();
        chk("ret2", bus.out, 32'h404);
        step();
        chk("ret3", bus.out, 32'h304);
        step();
        chk("ret4", bus.out, 32'h204);
        chk("ret4_count", 32'(bus.rasCount), 32'd0);
        step();
        idle();
        chk("ret5_out", bus.out, 32'h208);
        chk("ret5_udf", 32'(bus.rasUnderflow), 32'd1);
        step();
        chk("udf_clears", 32'(bus.rasUnderflow), 32'd0);
        chk("after_udf", bus.out, 32'h20C);

        call(32'h1000);
        call(32'h2000);
        call(32'h3000);
        chk("pre_reset_count", 32'(bus.rasCount), 32'd3);
        #2 rst = 1'b0;
        #1;
        chk("async_reset_out", bus.out, 32'h0);
        chk("async_reset_count", 32'(bus.rasCount), 32'd0);
        #2 rst = 1'b1;
        bus.retFlag = 1'b1;
        step();
        idle();
        chk("post_reset_ret_out", bus.out, 32'h4);
        chk("post_reset_udf", 32'(bus.rasUnderflow), 32'd1);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/pc_ras_unit.md
Name: pc_ras_unit

Overview:
Parametrised program-counter unit for the MIPS core. It is the successor to the single-width PC. It adds configurable width and reset vector, a pipeline stall, call/return control, and an internal circular return-address stack (RAS) so that jal/jr $ra resolve without a register-file read. It sits at the head of the fetch stage and drives the instruction-memory address.

Parameters:
WIDTH, 32, address width in bits.
RESET_VECTOR, 0, value loaded into out on reset.
RAS_DEPTH, 4, number of RAS entries; power of two, >= 2.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous, active-low reset (0 = reset asserted).
stall  input  1  holds PC and RAS; all control flags are ignored that cycle.
zeroflag  input  1  ALU zero result; qualifies branchFlag.
branchFlag  input  1  conditional branch instruction.
branchOffset  input  WIDTH  signed word offset (already sign-extended).
jmpFlag  input  1  unconditional jump.
jmpAddress  input  WIDTH  absolute jump/call target.
callFlag  input  1  jal: jump to jmpAddress and push return address.
retFlag  input  1  jr $ra: jump to RAS top and pop.
out  output  WIDTH  current PC (registered).
rasCount  output  clog2(RAS_DEPTH+1)  valid RAS entries.
rasOverflow  output  1  one-cycle pulse: push discarded the oldest entry.
rasUnderflow  output  1  one-cycle pulse: return attempted on an empty RAS.

Behaviour:
- Reset (rst=0, asynchronous): out=RESET_VECTOR, rasCount=0, write pointer=0, rasOverflow=0, rasUnderflow=0. Reset mid-operation takes effect immediately and discards all RAS contents.
- seq = out + 4, in WIDTH-bit arithmetic; wraps modulo 2^WIDTH with no flag.
- Next-PC priority (first match wins), updated on each rising edge when stall=0:
  1. retFlag: RAS non-empty -> out=top, pop. RAS empty -> out=seq and rasUnderflow=1.
  2. callFlag: out=jmpAddress, push seq.
  3. jmpFlag: out=jmpAddress.
  4. branchFlag & zeroflag: out = seq + (branchOffset << 2), truncated to WIDTH.
  5. Otherwise: out=seq. A branch with zeroflag=0 falls through here.
- stall=1: out, RAS, and rasCount hold; both pulses read 0; flags are not latched for later cycles.
- RAS is a circular buffer:
  - Push writes at the write pointer and increments it (mod RAS_DEPTH).
  - rasCount saturates at RAS_DEPTH. A push while full overwrites the oldest entry and pulses rasOverflow.
  - Pop decrements the pointer; top = entry[ptr-1].
- retFlag and callFlag in the same cycle: only the return executes (priority 1); there is no push.
- rasOverflow and rasUnderflow are registered and high for exactly the one cycle after the causing edge.
- Latency: one cycle from flag sampling to the new out. The RAS top is readable combinationally in the same cycle as retFlag.

Decomposition:
- Shared package pc_pkg holds:
  - INSTR_BYTES=4.
  - Next-PC select encoding: SEL_SEQ, SEL_BRANCH, SEL_JMP, SEL_CALL, SEL_RET.
  - Helper constant for the rasCount width.
- One sub-module, pc_ras_stack, contains storage, pointer, count, push/pop, and the overflow/underflow pulses.
- pc_ras_unit holds the priority select, the adders, and the PC register.

Test Plan:
- Reset held 50ns, then released, no flags -> out=0x0; after 4 edges out=0x10; rasCount=0.
- At out=0x10, branchFlag=1, zeroflag=1, branchOffset=-3 -> out=0x08. Same stimulus with zeroflag=0 -> out=0x14.
- jmpFlag=1, jmpAddress=0x340C -> out=0x340C, next edge 0x3410. stall=1 for 3 cycles during this -> out stays 0x3410, and a jmpFlag pulse during the stall is ignored.
- At out=0x100, callFlag=1, jmpAddress=0x2000 -> out=0x2000, rasCount=1. Then retFlag=1 -> out=0x104, rasCount=0. callFlag=retFlag=1 together -> return taken, rasCount unchanged.
- RAS_DEPTH=4: five calls from 0x100, 0x200, 0x300, 0x400, 0x500 -> rasOverflow pulses on the 5th, rasCount=4. Returns then give 0x504, 0x404, 0x304, 0x204. A 5th return -> rasUnderflow pulses and out = PC+4.
- rst driven low between clock edges with rasCount=3 -> out=RESET_VECTOR immediately (before the next edge), rasCount=0. After release, retFlag -> rasUnderflow pulses.
